// File: rtl/sobel_mac_sequencer.sv
// Sobel window sequencer: runs the X then Y coefficient/pixel streams through one
// shared MAC, then holds |Gx|+|Gy| and an edge flag under a valid/ready handshake.
module sobel_mac_sequencer #(
  parameter int ACC_W     = 12,
  parameter int NUM_TERMS = 6,
  parameter int TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    calc_enable_x,
  input  logic [4:0]              a_x,
  input  logic [4:0]              b_x,
  input  logic                    calc_done_x,
  output logic                    calc_enable_y,
  input  logic [4:0]              a_y,
  input  logic [4:0]              b_y,
  input  logic                    calc_done_y,
  input  logic [ACC_W:0]          threshold,
  output logic signed [ACC_W-1:0] gx,
  output logic signed [ACC_W-1:0] gy,
  output logic [ACC_W:0]          mag,
  output logic                    edge_flag,
  output logic                    term_err,
  output logic                    timeout_err,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERMS_C  = CNT_W'(NUM_TERMS);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_X,
    RUN_X,
    START_Y,
    RUN_Y,
    RESULT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]        term_cnt, cycle_cnt;
  logic signed [ACC_W-1:0] acc_x, acc_y;

  logic clear_window, pass_done, pass_timeout, mac_en, load_result, run_y;

  logic [4:0]              op_a, op_b;
  logic signed [10:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]          mag_next;

  // Absolute value at ACC_W+1 bits so the most negative accumulator is exact.
  function automatic logic [ACC_W:0] magnitude(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] w;
    logic [ACC_W:0]        r;
    w = (ACC_W+1)'(v);
    r = w[ACC_W] ? -w : w;
    return r;
  endfunction

  assign run_y    = (state == RUN_Y);
  assign op_a     = run_y ? a_y : a_x;
  assign op_b     = run_y ? b_y : b_x;
  assign prod     = 11'($signed(op_a)) * 11'($signed({1'b0, op_b}));
  assign prod_ext = ACC_W'(prod);
  assign mag_next = magnitude(acc_x) + magnitude(acc_y);

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b1;
    calc_enable_x = 1'b0;
    calc_enable_y = 1'b0;
    result_valid  = 1'b0;
    clear_window  = 1'b0;
    pass_done     = 1'b0;
    pass_timeout  = 1'b0;
    mac_en        = 1'b0;
    load_result   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clear_window = 1'b1;
          state_next   = START_X;
        end
      end
      START_X: begin
        calc_enable_x = 1'b1;
        state_next    = RUN_X;
      end
      RUN_X: begin
        if (calc_done_x) begin
          pass_done  = 1'b1;
          state_next = START_Y;
        end else if (cycle_cnt == CYC_LAST) begin
          pass_timeout = 1'b1;
          load_result  = 1'b1;
          state_next   = RESULT;
        end else begin
          mac_en = 1'b1;
        end
      end
      START_Y: begin
        calc_enable_y = 1'b1;
        state_next    = RUN_Y;
      end
      RUN_Y: begin
        if (calc_done_y) begin
          pass_done   = 1'b1;
          load_result = 1'b1;
          state_next  = RESULT;
        end else if (cycle_cnt == CYC_LAST) begin
          pass_timeout = 1'b1;
          load_result  = 1'b1;
          state_next   = RESULT;
        end else begin
          mac_en = 1'b1;
        end
      end
      RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_x       <= '0;
      acc_y       <= '0;
      term_cnt    <= '0;
      cycle_cnt   <= '0;
      term_err    <= 1'b0;
      timeout_err <= 1'b0;
      gx          <= '0;
      gy          <= '0;
      mag         <= '0;
      edge_flag   <= 1'b0;
    end else begin
      if (clear_window) begin
        acc_x       <= '0;
        acc_y       <= '0;
        term_cnt    <= '0;
        cycle_cnt   <= '0;
        term_err    <= 1'b0;
        timeout_err <= 1'b0;
        gx          <= '0;
        gy          <= '0;
        mag         <= '0;
        edge_flag   <= 1'b0;
      end
      if (mac_en) begin
        if (run_y) acc_y <= acc_y + prod_ext;
        else       acc_x <= acc_x + prod_ext;
        term_cnt  <= term_cnt + 1'b1;
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (pass_done) begin
        if (term_cnt != TERMS_C) term_err <= 1'b1;
        term_cnt  <= '0;
        cycle_cnt <= '0;
      end
      if (pass_timeout) timeout_err <= 1'b1;
      // Accumulators are final here: the exit cycle never accumulates.
      if (load_result) begin
        gx        <= acc_x;
        gy        <= acc_y;
        mag       <= mag_next;
        edge_flag <= (mag_next >= threshold);
      end
    end
  end

endmodule

// File: tb/tb_sobel_mac_sequencer.sv
// Scoreboard bench for sobel_mac_sequencer with behavioural X/Y bit-select models.
module tb_sobel_mac_sequencer;

  localparam int ACC_W   = 12;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic n_rst, start, result_ready;
  logic busy, calc_enable_x, calc_enable_y, calc_done_x, calc_done_y;
  logic [4:0] a_x, b_x, a_y, b_y;
  logic [ACC_W:0] threshold;
  logic signed [ACC_W-1:0] gx, gy;
  logic [ACC_W:0] mag;
  logic edge_flag, term_err, timeout_err, result_valid;

  always #5 clk = ~clk;

  sobel_mac_sequencer #(.ACC_W(ACC_W), .NUM_TERMS(6), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .busy(busy),
    .calc_enable_x(calc_enable_x), .a_x(a_x), .b_x(b_x), .calc_done_x(calc_done_x),
    .calc_enable_y(calc_enable_y), .a_y(a_y), .b_y(b_y), .calc_done_y(calc_done_y),
    .threshold(threshold), .gx(gx), .gy(gy), .mag(mag), .edge_flag(edge_flag),
    .term_err(term_err), .timeout_err(timeout_err),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bit-select models: terms follow the enable by one edge, then one done cycle.
  logic signed [4:0] xa[6], ya[6];
  logic [4:0] xb[6], yb[6];
  int x_n = 6, y_n = 6;
  int x_idx = 0, y_idx = 0;
  logic x_act = 1'b0, y_act = 1'b0;

  always @(posedge clk) begin
    if (calc_enable_x) begin x_act <= 1'b1; x_idx <= 0; end
    else if (x_act) begin
      if (x_idx == x_n) x_act <= 1'b0;
      else x_idx <= x_idx + 1;
    end
    if (calc_enable_y) begin y_act <= 1'b1; y_idx <= 0; end
    else if (y_act) begin
      if (y_idx == y_n) y_act <= 1'b0;
      else y_idx <= y_idx + 1;
    end
  end

  always_comb begin
    a_x = '0; b_x = '0; a_y = '0; b_y = '0;
    calc_done_x = x_act && (x_idx == x_n);
    calc_done_y = y_act && (y_idx == y_n);
    if (x_act && x_idx < x_n && x_idx < 6) begin a_x = xa[x_idx]; b_x = xb[x_idx]; end
    if (y_act && y_idx < y_n && y_idx < 6) begin a_y = ya[y_idx]; b_y = yb[y_idx]; end
  end

  typedef struct {
    logic signed [31:0] gx, gy, mag;
    logic edge_f, te, to;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  function automatic logic signed [ACC_W-1:0] pass_sum(input bit is_y, input int n);
    int s = 0;
    int nacc;
    nacc = (n > TIMEOUT - 1) ? TIMEOUT - 1 : n;
    for (int i = 0; i < nacc; i++)
      if (i < 6) s += is_y ? int'(ya[i]) * int'(yb[i]) : int'(xa[i]) * int'(xb[i]);
    return s[ACC_W-1:0];
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    logic x_to, y_to;
    x_to = (x_n > TIMEOUT - 1);
    y_to = (y_n > TIMEOUT - 1);
    e.gx = pass_sum(1'b0, x_n);
    e.gy = x_to ? 0 : pass_sum(1'b1, y_n);
    e.mag = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
    e.edge_f = (e.mag >= int'(threshold));
    e.te = (!x_to && x_n != 6) || (!x_to && !y_to && y_n != 6);
    e.to = x_to || (!x_to && y_to);
    return e;
  endfunction

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (sb.size() == 0) check("sb_extra", sb.size(), 1);
      else begin
        last_exp = sb.pop_front();
        check("gx", gx, last_exp.gx);
        check("gy", gy, last_exp.gy);
        check("mag", mag, last_exp.mag);
        check("edge", edge_flag, last_exp.edge_f);
        check("term_err", term_err, last_exp.te);
        check("timeout_err", timeout_err, last_exp.to);
      end
    end
    prev_valid <= result_valid;
  end

  task automatic do_window(input int pulse_at, output int lat, output int ex_at,
                           output int ey_at, output int ey_cnt);
    sb.push_back(make_exp());
    lat = -1; ex_at = -1; ey_at = -1; ey_cnt = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = (k == pulse_at);
      if (calc_enable_x && ex_at < 0) ex_at = k;
      if (calc_enable_y) begin ey_cnt++; if (ey_at < 0) ey_at = k; end
      if (result_valid) begin lat = k; break; end
    end
    start = 1'b0;
    if (lat < 0) check("valid_wait", lat, 17);
  endtask

  task automatic release_result();
    @(negedge clk); result_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_busy", busy, 0);
    check("rel_valid", result_valid, 0);
    result_ready = 1'b0;
  endtask

  task automatic set_flat();
    int coef[6] = '{-1, 1, -2, 2, -1, 1};
    for (int i = 0; i < 6; i++) begin
      xa[i] = 5'(coef[i]); ya[i] = 5'(coef[i]); xb[i] = 5'd5; yb[i] = 5'd5;
    end
  endtask

  task automatic set_vertical();
    set_flat();
    for (int i = 0; i < 6; i++) begin
      xb[i] = (i % 2 == 1) ? 5'd15 : 5'd0; yb[i] = 5'd15;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ex, ey, eyc, cnt_en, cnt_busy;
    n_rst = 1'b0; start = 1'b0; result_ready = 1'b0; threshold = '0;
    set_flat();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_enx", calc_enable_x, 0);
    check("rst_gx", gx, 0);
    check("rst_mag", mag, 0);
    check("rst_errs", {term_err, timeout_err}, 0);
    @(negedge clk); n_rst = 1'b1;

    // Flat window, with latency measured from the cycle start is presented.
    set_flat(); threshold = 13'd1;
    do_window(0, lat, ex, ey, eyc);
    check("flat_lat", lat, 17);
    check("flat_enx", ex, 1);
    check("flat_eny", ey, 9);
    release_result();

    set_vertical(); threshold = 13'd32;
    do_window(0, lat, ex, ey, eyc);
    check("vert_lat", lat, 17);
    release_result();

    // Extremes; threshold equal to mag exercises the >= boundary.
    for (int i = 0; i < 6; i++) begin
      xa[i] = -5'sd16; ya[i] = -5'sd16; xb[i] = 5'd15; yb[i] = 5'd15;
    end
    threshold = 13'd2880;
    do_window(0, lat, ex, ey, eyc);
    release_result();
    for (int i = 0; i < 6; i++) begin xb[i] = 5'd0; yb[i] = 5'd0; end
    threshold = 13'd0;
    do_window(0, lat, ex, ey, eyc);
    release_result();

    // Short X pass: term error, Y still runs.
    set_vertical(); threshold = 13'd32; x_n = 5;
    do_window(0, lat, ex, ey, eyc);
    check("short_eny_cnt", eyc, 1);
    release_result();

    // X never finishes: timeout, no Y pass, valid 16 edges after the window opens.
    x_n = 99;
    do_window(0, lat, ex, ey, eyc);
    check("to_lat", lat - ex, 16);
    check("to_eny_cnt", eyc, 0);
    release_result();
    x_n = 6;

    // Handshake: start pulse mid-window and during a held RESULT.
    set_vertical(); threshold = 13'd32;
    do_window(5, lat, ex, ey, eyc);
    check("hs_lat", lat, 17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = (i == 4);
      check("hs_valid", result_valid, 1);
      check("hs_gx", gx, last_exp.gx);
      check("hs_mag", mag, last_exp.mag);
      check("hs_edge", edge_flag, last_exp.edge_f);
    end
    start = 1'b0;
    release_result();
    cnt_busy = 0;
    repeat (3) begin @(posedge clk); #1; if (busy) cnt_busy++; end
    check("hs_no_queue", cnt_busy, 0);
    set_flat(); threshold = 13'd1;
    do_window(0, lat, ex, ey, eyc);
    check("hs_next_lat", lat, 17);
    release_result();

    // Reset in the middle of RUN_Y.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ey = 0;
    for (int k = 0; k < 30 && ey == 0; k++) begin
      @(posedge clk); #1;
      if (calc_enable_y) ey = 1;
    end
    check("rst_eny_seen", ey, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); n_rst = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 0);
    check("mid_gx", gx, 0);
    check("mid_gy", gy, 0);
    check("mid_mag", mag, 0);
    check("mid_flags", {edge_flag, term_err, timeout_err, result_valid}, 0);
    @(negedge clk); n_rst = 1'b1;
    cnt_en = 0; cnt_busy = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (calc_enable_x || calc_enable_y) cnt_en++;
      if (busy || result_valid) cnt_busy++;
    end
    check("post_rst_en", cnt_en, 0);
    check("post_rst_busy", cnt_busy, 0);

    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
